vga_scroll_timing: RTL and testbench

Parametrised successor to the fixed 640x480 VGA output stage. It generates VGA timing from configurable porch and sync parameters and produces framebuffer ROM addresses for a background image wider than the screen, with a horizontal scroll offset that wraps at the image width. Sync and blanking are delayed to match a configurable ROM read latency. It sits between the scroll logic (offset source) and the background block memory, and drives the VGA pins.

---
 rtl/vga_pkg.sv | 45 ++++
 rtl/vga_delay_line.sv | 36 +++
 rtl/vga_scroll_timing.sv | 134 +++++++++++++
 tb/tb_vga_scroll_timing.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Default 640x480@60 timing, derived line/frame positions and the colour-bar palette
// shared by the VGA scroll output stage.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL     = VGA_H_SYNC + VGA_H_BP + VGA_H_ACTIVE + VGA_H_FP;
  localparam int VGA_V_TOTAL     = VGA_V_SYNC + VGA_V_BP + VGA_V_ACTIVE + VGA_V_FP;
  localparam int VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_H_ACT_END   = VGA_H_ACT_START + VGA_H_ACTIVE;
  localparam int VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BP;
  localparam int VGA_V_ACT_END   = VGA_V_ACT_START + VGA_V_ACTIVE;

  localparam int VGA_RGB_W = 12;

  localparam logic [11:0] BAR_WHITE   = 12'hFFF;
  localparam logic [11:0] BAR_YELLOW  = 12'hFF0;
  localparam logic [11:0] BAR_CYAN    = 12'h0FF;
  localparam logic [11:0] BAR_GREEN   = 12'h0F0;
  localparam logic [11:0] BAR_MAGENTA = 12'hF0F;
  localparam logic [11:0] BAR_RED     = 12'hF00;
  localparam logic [11:0] BAR_BLUE    = 12'h00F;
  localparam logic [11:0] BAR_BLACK   = 12'h000;

  function automatic logic [11:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Resettable DEPTH-stage shift register; every stage resets to RST_VAL.
// Latency DEPTH clocks, no backpressure.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_25mhz,
  input  logic             Rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scroll_timing.sv
// VGA timing plus scrolled background ROM addressing; pins lag the counters by 1+MEM_LAT clocks.
// Define VGA_TEST_PATTERN_EN to replace ROM data with eight vertical colour bars.
module vga_scroll_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_TOTAL - VGA_H_ACT_END,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_ACT_START - VGA_H_SYNC,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_TOTAL - VGA_V_ACT_END,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_ACT_START - VGA_V_SYNC,
  parameter int BG_WIDTH = 1280,
  parameter int ADDR_W   = 19,
  parameter int RGB_W    = VGA_RGB_W,
  parameter int SCROLL_W = 11,
  parameter int MEM_LAT  = 1
) (
  input  logic                clk_25mhz,
  input  logic                Rst_n,
  input  logic [SCROLL_W-1:0] scroll_x,
  input  logic [RGB_W-1:0]    data_in,
  output logic [ADDR_W-1:0]   vram_address,
  output logic [9:0]          x_pixel,
  output logic [9:0]          y_pixel,
  output logic [RGB_W-1:0]    VGA_RGB,
  output logic                VGA_HSYNC,
  output logic                VGA_VSYNC,
  output logic                VGA_BLOCK,
  output logic                frame_start
);

  localparam int          D        = 1 + MEM_LAT;
  localparam int          PW       = 23;
  localparam logic [9:0]  H_LAST   = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam logic [9:0]  HS_END   = 10'(H_SYNC);
  localparam logic [9:0]  VS_END   = 10'(V_SYNC);
  localparam logic [9:0]  HA_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  HA_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0]  HA_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0]  COL_LOAD = 10'(H_SYNC + H_BP - 1);
  localparam logic [9:0]  VA_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VA_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [SCROLL_W-1:0] BG_W     = SCROLL_W'(BG_WIDTH);
  localparam logic [SCROLL_W-1:0] COL_LAST = SCROLL_W'(BG_WIDTH - 1);
  localparam logic [ADDR_W-1:0]   ROW_STEP = ADDR_W'(BG_WIDTH);
  localparam logic [PW-1:0]       PIPE_RST = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0};

  logic [9:0]          hcount_q, hcount_d, vcount_q, vcount_d;
  logic [SCROLL_W-1:0] scroll_q, scroll_d, col_q, col_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d, vram_address_q, vram_address_d;
  logic                h_act, v_act, act, hsync_raw, vsync_raw, fs_raw;
  logic [9:0]          x_raw, y_raw;
  logic [PW-1:0]       pipe_out;

  always_comb begin
    h_act     = (hcount_q >= HA_START) && (hcount_q < HA_END);
    v_act     = (vcount_q >= VA_START) && (vcount_q < VA_END);
    act       = h_act && v_act;
    hsync_raw = (hcount_q >= HS_END);
    vsync_raw = (vcount_q >= VS_END);
    fs_raw    = (hcount_q == 10'd0) && (vcount_q == 10'd0);
    x_raw     = act ? hcount_q - HA_START : 10'd0;
    y_raw     = act ? vcount_q - VA_START : 10'd0;
  end

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = 10'd0;
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end

    // Out-of-range offsets are dropped so the image column never leaves the ROM row.
    scroll_d = scroll_q;
    if (fs_raw && (scroll_x < BG_W)) scroll_d = scroll_x;

    col_d = col_q;
    if (hcount_q == COL_LOAD) col_d = scroll_q;
    else if (act)             col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;

    row_base_d = row_base_q;
    if (fs_raw)                              row_base_d = '0;
    else if (v_act && (hcount_q == HA_LAST)) row_base_d = row_base_q + ROW_STEP;

    vram_address_d = act ? row_base_q + ADDR_W'(col_q) : '0;
  end

  always_ff @(posedge clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      hcount_q       <= '0;
      vcount_q       <= '0;
      scroll_q       <= '0;
      col_q          <= '0;
      row_base_q     <= '0;
      vram_address_q <= '0;
    end else begin
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      scroll_q       <= scroll_d;
      col_q          <= col_d;
      row_base_q     <= row_base_d;
      vram_address_q <= vram_address_d;
    end
  end

  vga_delay_line #(
    .DEPTH   (D),
    .WIDTH   (PW),
    .RST_VAL (PIPE_RST)
  ) u_dly (
    .clk_25mhz (clk_25mhz),
    .Rst_n     (Rst_n),
    .din       ({hsync_raw, vsync_raw, act, x_raw, y_raw}),
    .dout      (pipe_out)
  );

  assign {VGA_HSYNC, VGA_VSYNC, VGA_BLOCK, x_pixel, y_pixel} = pipe_out;
  assign vram_address = vram_address_q;
  // Counters sit at 0/0 while in reset; keep the pulse low until reset is released.
  assign frame_start  = fs_raw & Rst_n;

`ifdef VGA_TEST_PATTERN_EN
  logic unused_data_in;
  assign unused_data_in = ^data_in;
  assign VGA_RGB = VGA_BLOCK ? RGB_W'(bar_colour(3'(x_pixel / 10'(H_ACTIVE / 8)))) : '0;
`else
  assign VGA_RGB = VGA_BLOCK ? data_in : '0;
`endif

endmodule

// File: tb/tb_vga_scroll_timing.sv
// Bench: 640x480 instance (MEM_LAT=1) for line timing/alignment, a shrunken-timing
// instance (MEM_LAT=3, BG_WIDTH=48) for frame-level scroll, wrap and latency cases.
module tb_vga_scroll_timing;

  logic        clk_25mhz = 1'b0;
  logic        Rst_n     = 1'b0;
  logic [10:0] scroll_a  = 11'd0;
  logic [10:0] scroll_b  = 11'd40;

  always #5 clk_25mhz = ~clk_25mhz;

  logic [18:0] addr_a, addr_b;
  logic [9:0]  x_a, y_a, x_b, y_b;
  logic [11:0] rgb_a, rgb_b;
  logic        hs_a, vs_a, blk_a, fs_a, hs_b, vs_b, blk_b, fs_b;
  logic [11:0] rom_a = '0, rom_b0 = '0, rom_b1 = '0, rom_b2 = '0;

  vga_scroll_timing dut_a (
    .clk_25mhz(clk_25mhz), .Rst_n(Rst_n), .scroll_x(scroll_a), .data_in(rom_a),
    .vram_address(addr_a), .x_pixel(x_a), .y_pixel(y_a), .VGA_RGB(rgb_a),
    .VGA_HSYNC(hs_a), .VGA_VSYNC(vs_a), .VGA_BLOCK(blk_a), .frame_start(fs_a)
  );

  vga_scroll_timing #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(6),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .BG_WIDTH(48), .MEM_LAT(3)
  ) dut_b (
    .clk_25mhz(clk_25mhz), .Rst_n(Rst_n), .scroll_x(scroll_b), .data_in(rom_b2),
    .vram_address(addr_b), .x_pixel(x_b), .y_pixel(y_b), .VGA_RGB(rgb_b),
    .VGA_HSYNC(hs_b), .VGA_VSYNC(vs_b), .VGA_BLOCK(blk_b), .frame_start(fs_b)
  );

  // ROM models return the low 12 address bits after 1 and 3 clocks.
  always @(posedge clk_25mhz) begin
    rom_a  <= addr_a[11:0];
    rom_b0 <= addr_b[11:0];
    rom_b1 <= rom_b0;
    rom_b2 <= rom_b1;
  end

  int cyc;
  always @(posedge clk_25mhz or negedge Rst_n) begin
    if (!Rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          k;
    logic [10:0] sc;
    logic        fs, hs, vs, blk;
    logic [11:0] rgb;
    logic [9:0]  x, y;
    logic [18:0] addr;
  } vec_t;

  function automatic vec_t mk(int k, int sc, int fs, int hs, int vs, int blk,
                              int rgb, int x, int y, int addr);
    vec_t v;
    v.k = k;  v.sc = 11'(sc);
    v.fs = (fs != 0); v.hs = (hs != 0); v.vs = (vs != 0); v.blk = (blk != 0);
    v.rgb = 12'(rgb); v.x = 10'(x); v.y = 10'(y); v.addr = 19'(addr);
    return v;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t e, input logic fs, input logic hs,
                         input logic vs, input logic blk, input logic [11:0] rgb,
                         input logic [9:0] x, input logic [9:0] y, input logic [18:0] addr);
    chk({tag, ".frame_start"}, int'(fs), int'(e.fs));
    chk({tag, ".hsync"},       int'(hs), int'(e.hs));
    chk({tag, ".vsync"},       int'(vs), int'(e.vs));
    chk({tag, ".block"},       int'(blk), int'(e.blk));
    chk({tag, ".rgb"},         int'(rgb), int'(e.rgb));
    chk({tag, ".x"},           int'(x), int'(e.x));
    chk({tag, ".y"},           int'(y), int'(e.y));
    chk({tag, ".addr"},        int'(addr), int'(e.addr));
  endtask

  task automatic wait_k(input int k);
    int guard = 0;
    while (cyc < k && guard < 200000) begin
      @(negedge clk_25mhz);
      guard++;
    end
    #1;
    if (cyc != k) begin
      checks++;
      errors++;
      $display("FAIL wait_k cycle=%0d want=%0d", cyc, k);
    end
  endtask

  vec_t ta [16];
  vec_t tv [21];
  vec_t rst_v;

  initial begin
    rst_v = mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);

    // 640x480, scroll 0: k = clocks since reset release (fields: k, scroll, fs, hs, vs, blk, rgb, x, y, addr)
    ta[0]  = mk(0,     0, 1, 1, 1, 0,    0,   0,  0,     0);
    ta[1]  = mk(1,     0, 0, 1, 1, 0,    0,   0,  0,     0);
    ta[2]  = mk(2,     0, 0, 0, 0, 0,    0,   0,  0,     0);
    ta[3]  = mk(97,    0, 0, 0, 0, 0,    0,   0,  0,     0);
    ta[4]  = mk(98,    0, 0, 1, 0, 0,    0,   0,  0,     0);
    ta[5]  = mk(801,   0, 0, 1, 0, 0,    0,   0,  0,     0);
    ta[6]  = mk(802,   0, 0, 0, 0, 0,    0,   0,  0,     0);
    ta[7]  = mk(1601,  0, 0, 1, 0, 0,    0,   0,  0,     0);
    ta[8]  = mk(1602,  0, 0, 0, 1, 0,    0,   0,  0,     0);
    ta[9]  = mk(28145, 0, 0, 1, 1, 0,    0,   0,  0,     0);
    ta[10] = mk(28146, 0, 0, 1, 1, 1,    0,   0,  0,     1);
    ta[11] = mk(28147, 0, 0, 1, 1, 1,    1,   1,  0,     2);
    ta[12] = mk(28785, 0, 0, 1, 1, 1,  639, 639,  0,     0);
    ta[13] = mk(28786, 0, 0, 1, 1, 0,    0,   0,  0,     0);
    ta[14] = mk(28946, 0, 0, 1, 1, 1, 1280,   0,  1,  1281);
    ta[15] = mk(40400, 0, 0, 1, 1, 1, 3070, 254, 15, 19455);

    // Small timing: H 8/6/32/4 (50), V 2/3/6/2 (13), BG 48, output delay 4
    tv[0]  = mk(0,    40, 1, 1, 1, 0,   0,  0, 0,   0);
    tv[1]  = mk(3,    40, 0, 1, 1, 0,   0,  0, 0,   0);
    tv[2]  = mk(4,    40, 0, 0, 0, 0,   0,  0, 0,   0);
    tv[3]  = mk(11,   40, 0, 0, 0, 0,   0,  0, 0,   0);
    tv[4]  = mk(12,   40, 0, 1, 0, 0,   0,  0, 0,   0);
    tv[5]  = mk(103,  40, 0, 1, 0, 0,   0,  0, 0,   0);
    tv[6]  = mk(104,  40, 0, 0, 1, 0,   0,  0, 0,   0);
    tv[7]  = mk(265,  40, 0, 1, 1, 0,   0,  0, 0,  40);
    tv[8]  = mk(268,  40, 0, 1, 1, 1,  40,  0, 0,  43);
    tv[9]  = mk(273,  40, 0, 1, 1, 1,  45,  5, 0,   0);
    tv[10] = mk(277,  40, 0, 1, 1, 1,   1,  9, 0,   4);
    tv[11] = mk(297,  40, 0, 1, 1, 1,  21, 29, 0,   0);
    tv[12] = mk(368,  40, 0, 1, 1, 1, 136,  0, 2, 139);
    tv[13] = mk(400,  10, 0, 1, 1, 0,   0,  0, 0,   0);
    tv[14] = mk(465,  10, 0, 1, 1, 0,   0,  0, 0, 232);
    tv[15] = mk(649,  10, 0, 1, 1, 0,   0,  0, 0,   0);
    tv[16] = mk(650,  10, 1, 1, 1, 0,   0,  0, 0,   0);
    tv[17] = mk(651,  10, 0, 1, 1, 0,   0,  0, 0,   0);
    tv[18] = mk(915,  10, 0, 1, 1, 0,   0,  0, 0,  10);
    tv[19] = mk(1000, 48, 0, 1, 1, 0,   0,  0, 0,   0);
    tv[20] = mk(1568, 48, 0, 1, 1, 1,  10,  0, 0,  13);

    repeat (3) @(negedge clk_25mhz);
    #1;
    chk_vec("rst_a", rst_v, fs_a, hs_a, vs_a, blk_a, rgb_a, x_a, y_a, addr_a);
    chk_vec("rst_b", rst_v, fs_b, hs_b, vs_b, blk_b, rgb_b, x_b, y_b, addr_b);
    Rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      wait_k(ta[i].k);
      scroll_a = ta[i].sc;
      chk_vec($sformatf("A%0d", i), ta[i], fs_a, hs_a, vs_a, blk_a, rgb_a, x_a, y_a, addr_a);
    end

    // Reset in the middle of an active line (h=400, v=50)
    Rst_n = 1'b0;
    #1;
    chk_vec("rst_mid_a", rst_v, fs_a, hs_a, vs_a, blk_a, rgb_a, x_a, y_a, addr_a);
    scroll_b = 11'd40;
    repeat (2) @(negedge clk_25mhz);
    Rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      wait_k(tv[i].k);
      scroll_b = tv[i].sc;
      chk_vec($sformatf("B%0d", i), tv[i], fs_b, hs_b, vs_b, blk_b, rgb_b, x_b, y_b, addr_b);
    end

    // Reset mid active line of the small instance, then frame_start on the first clock
    wait_k(1620);
    chk("pre_rst_b.block", int'(blk_b), 1);
    Rst_n = 1'b0;
    #1;
    chk_vec("rst_mid_b", rst_v, fs_b, hs_b, vs_b, blk_b, rgb_b, x_b, y_b, addr_b);
    @(negedge clk_25mhz);
    Rst_n = 1'b1;
    #1;
    chk("rel_b.frame_start", int'(fs_b), 1);
    @(negedge clk_25mhz);
    #1;
    chk("rel_b.frame_start_clk1", int'(fs_b), 0);
    chk("rel_b.hsync_clk1", int'(hs_b), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
